// File: rtl/ext_int_ctl.sv
// External interrupt aggregator: synchronises device lines, latches edge/level pending bits,
// and offers a claim/complete register port that feeds the core's exti request.
module ext_int_ctl #(
    parameter int NumSrc     = 8,
    parameter int SyncStages = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NumSrc-1:0] irq_src,
    input  logic              reg_req,
    input  logic              reg_we,
    input  logic [1:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              reg_ack,
    output logic              exti
);

    localparam logic [1:0] AddrPending = 2'd0;
    localparam logic [1:0] AddrEnable  = 2'd1;
    localparam logic [1:0] AddrEdge    = 2'd2;
    localparam logic [1:0] AddrClaim   = 2'd3;

    logic [SyncStages-1:0][NumSrc-1:0] syncQ;
    logic [NumSrc-1:0]                 sdDlyQ;
    logic [NumSrc-1:0]                 pendingQ,   pendingD;
    logic [NumSrc-1:0]                 enableQ,    enableD;
    logic [NumSrc-1:0]                 edgeQ,      edgeD;
    logic [NumSrc-1:0]                 inServiceQ, inServiceD;
    logic                              extiQ,      extiD;
    logic                              ackQ,       ackD;
    logic [31:0]                       rdataQ,     rdataD;

    logic [NumSrc-1:0] syncOut;
    logic [NumSrc-1:0] eligible;
    logic [NumSrc-1:0] claimMask;
    logic [NumSrc-1:0] claimGrant;
    logic [NumSrc-1:0] complMask;
    logic [NumSrc-1:0] w1cMask;
    logic [NumSrc-1:0] riseSet;
    logic [NumSrc-1:0] edgeClr;
    logic [4:0]        claimId;
    logic [4:0]        complId;
    logic [31:0]       readData;
    logic              wrEn;
    logic              rdEn;
    logic              wrPending;
    logic              wrEnable;
    logic              wrEdge;
    logic              wrClaim;
    logic              rdClaim;

    assign syncOut  = syncQ[SyncStages-1];
    assign eligible = pendingQ & enableQ & ~inServiceQ;

    assign wrEn      = reg_req & reg_we;
    assign rdEn      = reg_req & ~reg_we;
    assign wrPending = wrEn && (reg_addr == AddrPending);
    assign wrEnable  = wrEn && (reg_addr == AddrEnable);
    assign wrEdge    = wrEn && (reg_addr == AddrEdge);
    assign wrClaim   = wrEn && (reg_addr == AddrClaim);
    assign rdClaim   = rdEn && (reg_addr == AddrClaim);
    assign complId   = reg_wdata[4:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncQ  <= '0;
            sdDlyQ <= '0;
        end else begin
            syncQ  <= {syncQ[SyncStages-2:0], irq_src};
            sdDlyQ <= syncOut;
        end
    end

    // Lowest index wins: scan downward so the last hit is the smallest eligible source.
    always_comb begin
        claimId   = '0;
        claimMask = '0;
        for (int i = NumSrc - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                claimId      = 5'(i + 1);
                claimMask    = '0;
                claimMask[i] = 1'b1;
            end
        end
    end

    assign claimGrant = rdClaim ? claimMask : '0;

    always_comb begin
        complMask = '0;
        if (wrClaim) begin
            for (int i = 0; i < NumSrc; i++) begin
                if (complId == 5'(i + 1)) begin
                    complMask[i] = inServiceQ[i];
                end
            end
        end
    end

    assign w1cMask = wrPending ? reg_wdata[NumSrc-1:0] : '0;
    assign riseSet = edgeQ & syncOut & ~sdDlyQ;
    assign edgeClr = edgeQ & (w1cMask | claimGrant);

    // A rising edge arriving with a clear in the same cycle must survive.
    always_comb begin
        pendingD   = (~edgeQ & syncOut) | (edgeQ & ((pendingQ & ~edgeClr) | riseSet));
        enableD    = wrEnable ? reg_wdata[NumSrc-1:0] : enableQ;
        edgeD      = wrEdge ? reg_wdata[NumSrc-1:0] : edgeQ;
        inServiceD = (inServiceQ | claimGrant) & ~complMask;
        extiD      = |eligible;
    end

    always_comb begin
        readData = '0;
        case (reg_addr)
            AddrPending: readData = 32'(pendingQ);
            AddrEnable:  readData = 32'(enableQ);
            AddrEdge:    readData = 32'(edgeQ);
            AddrClaim:   readData = 32'(claimId);
            default:     readData = '0;
        endcase
    end

    always_comb begin
        ackD   = reg_req;
        rdataD = rdataQ;
        if (rdEn) begin
            rdataD = readData;
        end else if (wrEn) begin
            rdataD = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendingQ   <= '0;
            enableQ    <= '0;
            edgeQ      <= '0;
            inServiceQ <= '0;
            extiQ      <= 1'b0;
            ackQ       <= 1'b0;
            rdataQ     <= '0;
        end else begin
            pendingQ   <= pendingD;
            enableQ    <= enableD;
            edgeQ      <= edgeD;
            inServiceQ <= inServiceD;
            extiQ      <= extiD;
            ackQ       <= ackD;
            rdataQ     <= rdataD;
        end
    end

    assign reg_rdata = rdataQ;
    assign reg_ack   = ackQ;
    assign exti      = extiQ;

endmodule

// File: tb/tb_ext_int_ctl.sv
// Directed bench for ext_int_ctl: register accesses and irq pulses with hand-computed
// expectations for latency, priority, collisions, bad completions and reset.
module tb_ext_int_ctl;

    localparam int NumSrc = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NumSrc-1:0] irq_src;
    logic              reg_req;
    logic              reg_we;
    logic [1:0]        reg_addr;
    logic [31:0]       reg_wdata;
    logic [31:0]       reg_rdata;
    logic              reg_ack;
    logic              exti;

    int compared   = 0;
    int mismatched = 0;

    ext_int_ctl #(.NumSrc(NumSrc), .SyncStages(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src   (irq_src),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .exti      (exti)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One bus access: driven at the falling edge, result sampled just after the next rising edge.
    task automatic applyStimulus(input logic we, input logic [1:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata);
        @(negedge clk);
        reg_req   = 1'b1;
        reg_we    = we;
        reg_addr  = addr;
        reg_wdata = wdata;
        @(posedge clk);
        #1;
        reg_req = 1'b0;
        reg_we  = 1'b0;
        checkOutput("ack", 32'(reg_ack), 32'd1);
        if (we) checkOutput("wr_rdata_zero", reg_rdata, 32'd0);
        rdata = reg_rdata;
    endtask

    task automatic regWrite(input logic [1:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        applyStimulus(1'b1, addr, data, dummy);
    endtask

    task automatic readCheck(input string tag, input logic [1:0] addr, input logic [31:0] expected);
        logic [31:0] data;
        applyStimulus(1'b0, addr, 32'd0, data);
        checkOutput(tag, data, expected);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NumSrc-1:0] mask);
        @(negedge clk);
        irq_src = irq_src | mask;
        @(negedge clk);
        irq_src = irq_src & ~mask;
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        irq_src   = '0;
        reg_req   = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = 2'd0;
        reg_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ack", 32'(reg_ack), 32'd0);
        checkOutput("rst_rdata", reg_rdata, 32'd0);
        checkOutput("rst_exti", 32'(exti), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        readCheck("rst_pending", 2'd0, 32'd0);
        readCheck("rst_enable", 2'd1, 32'd0);
        readCheck("rst_edge", 2'd2, 32'd0);
        readCheck("rst_claim", 2'd3, 32'd0);

        $display("[TB] test 1: edge latency and claim");
        regWrite(2'd2, 32'h1);
        regWrite(2'd1, 32'h1);
        @(negedge clk);
        irq_src[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        irq_src[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("t1_exti_e3", 32'(exti), 32'd0);
        readCheck("t1_pending_e3", 2'd0, 32'h1);
        checkOutput("t1_exti_e4", 32'(exti), 32'd1);
        readCheck("t1_claim", 2'd3, 32'd1);
        checkOutput("t1_exti_claim_edge", 32'(exti), 32'd1);
        readCheck("t1_pending_cleared", 2'd0, 32'h0);
        checkOutput("t1_exti_dropped", 32'(exti), 32'd0);
        regWrite(2'd3, 32'd1);
        readCheck("t1_claim_none", 2'd3, 32'd0);

        $display("[TB] test 2: level source");
        regWrite(2'd2, 32'h0);
        regWrite(2'd1, 32'h4);
        @(negedge clk);
        irq_src[2] = 1'b1;
        cycles(4);
        checkOutput("t2_exti_on", 32'(exti), 32'd1);
        readCheck("t2_claim", 2'd3, 32'd3);
        cycles(1);
        checkOutput("t2_exti_in_service", 32'(exti), 32'd0);
        readCheck("t2_pending_level", 2'd0, 32'h4);
        regWrite(2'd3, 32'd3);
        cycles(1);
        checkOutput("t2_exti_after_complete", 32'(exti), 32'd1);
        @(negedge clk);
        irq_src[2] = 1'b0;
        cycles(4);
        checkOutput("t2_exti_released", 32'(exti), 32'd0);
        readCheck("t2_pending_released", 2'd0, 32'h0);

        $display("[TB] test 3: priority and enable masking");
        regWrite(2'd2, 32'h22);
        regWrite(2'd1, 32'h22);
        pulse(8'h22);
        cycles(3);
        readCheck("t3_pending", 2'd0, 32'h22);
        readCheck("t3_claim_a", 2'd3, 32'd2);
        readCheck("t3_claim_b", 2'd3, 32'd6);
        readCheck("t3_claim_c", 2'd3, 32'd0);
        checkOutput("t3_exti_empty", 32'(exti), 32'd0);
        regWrite(2'd3, 32'd2);
        regWrite(2'd3, 32'd6);
        pulse(8'h02);
        cycles(3);
        checkOutput("t3_exti_src1", 32'(exti), 32'd1);
        regWrite(2'd1, 32'h0);
        cycles(1);
        checkOutput("t3_exti_disabled", 32'(exti), 32'd0);
        readCheck("t3_pending_retained", 2'd0, 32'h02);
        regWrite(2'd0, 32'h02);
        readCheck("t3_pending_w1c", 2'd0, 32'h0);

        $display("[TB] test 4: collisions");
        regWrite(2'd2, 32'h08);
        regWrite(2'd1, 32'h08);
        pulse(8'h08);
        cycles(3);
        readCheck("t4_pending", 2'd0, 32'h08);
        @(negedge clk);
        irq_src[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        irq_src[3] = 1'b0;
        @(posedge clk);
        regWrite(2'd0, 32'h08);
        readCheck("t4_set_wins", 2'd0, 32'h08);
        regWrite(2'd0, 32'h08);
        readCheck("t4_w1c_plain", 2'd0, 32'h0);
        pulse(8'h08);
        cycles(3);
        checkOutput("t4_exti_on", 32'(exti), 32'd1);
        readCheck("t4_claim", 2'd3, 32'd4);
        pulse(8'h08);
        cycles(3);
        readCheck("t4_pending_in_service", 2'd0, 32'h08);
        checkOutput("t4_exti_blocked", 32'(exti), 32'd0);
        regWrite(2'd3, 32'd4);
        cycles(1);
        checkOutput("t4_exti_reasserted", 32'(exti), 32'd1);
        readCheck("t4_claim_again", 2'd3, 32'd4);
        regWrite(2'd3, 32'd4);

        $display("[TB] test 5: bad completions and register width");
        regWrite(2'd2, 32'h1);
        regWrite(2'd1, 32'h1);
        pulse(8'h01);
        cycles(3);
        readCheck("t5_claim", 2'd3, 32'd1);
        pulse(8'h01);
        cycles(3);
        checkOutput("t5_exti_blocked", 32'(exti), 32'd0);
        regWrite(2'd3, 32'd0);
        regWrite(2'd3, 32'(NumSrc + 1));
        regWrite(2'd3, 32'd2);
        cycles(1);
        checkOutput("t5_exti_still_blocked", 32'(exti), 32'd0);
        readCheck("t5_claim_blocked", 2'd3, 32'd0);
        regWrite(2'd3, 32'd1);
        cycles(1);
        checkOutput("t5_exti_after_good", 32'(exti), 32'd1);
        readCheck("t5_claim_again", 2'd3, 32'd1);
        regWrite(2'd3, 32'd1);
        regWrite(2'd1, 32'hFFFF_FFFF);
        readCheck("t5_enable_width", 2'd1, 32'h0000_00FF);
        regWrite(2'd2, 32'hFFFF_FF5A);
        readCheck("t5_edge_width", 2'd2, 32'h0000_005A);
        cycles(1);
        checkOutput("t5_ack_idle", 32'(reg_ack), 32'd0);
        checkOutput("t5_rdata_hold", reg_rdata, 32'h0000_005A);

        $display("[TB] test 6: reset during access");
        regWrite(2'd2, 32'h1);
        regWrite(2'd1, 32'h1);
        pulse(8'h01);
        cycles(3);
        checkOutput("t6_exti_setup", 32'(exti), 32'd1);
        @(negedge clk);
        reg_req  = 1'b1;
        reg_we   = 1'b0;
        reg_addr = 2'd3;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_exti_reset", 32'(exti), 32'd0);
        @(posedge clk);
        #1;
        reg_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        checkOutput("t6_no_ack_1", 32'(reg_ack), 32'd0);
        cycles(1);
        checkOutput("t6_no_ack_2", 32'(reg_ack), 32'd0);

        regWrite(2'd2, 32'h1);
        regWrite(2'd1, 32'h1);
        pulse(8'h01);
        cycles(3);
        @(negedge clk);
        reg_req  = 1'b1;
        reg_we   = 1'b0;
        reg_addr = 2'd3;
        @(posedge clk);
        #1;
        reg_req = 1'b0;
        checkOutput("t6_claim_ack", 32'(reg_ack), 32'd1);
        checkOutput("t6_claim_data", reg_rdata, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_ack_killed", 32'(reg_ack), 32'd0);
        checkOutput("t6_rdata_reset", reg_rdata, 32'd0);
        checkOutput("t6_exti_killed", 32'(exti), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        checkOutput("t6_no_ack_3", 32'(reg_ack), 32'd0);
        readCheck("t6_pending", 2'd0, 32'd0);
        readCheck("t6_enable", 2'd1, 32'd0);
        readCheck("t6_edge", 2'd2, 32'd0);
        readCheck("t6_claim", 2'd3, 32'd0);
        checkOutput("t6_exti_final", 32'(exti), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
